// File: rtl/fir_post_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fir_post_pkg: shared widths and rounding/saturation helpers for the
// FIR output conditioner.                                    Rev 1.0
// ---------------------------------------------------------------------------
package fir_post_pkg;

  localparam int ACC_WIDTH = 48;
  localparam int OUT_WIDTH = 18;

  typedef struct packed {
    logic signed [ACC_WIDTH:0] max;
    logic signed [ACC_WIDTH:0] min;
  } sat_lim_t;

  // One guard bit above the accumulator keeps the rounding bias from wrapping.
  function automatic logic signed [ACC_WIDTH:0] round_shift(
    input logic signed [ACC_WIDTH-1:0] value,
    input int                          shift
  );
    logic signed [ACC_WIDTH:0] ext;
    logic signed [ACC_WIDTH:0] bias;
    ext  = {value[ACC_WIDTH-1], value};
    bias = {{ACC_WIDTH{1'b0}}, 1'b1} << (shift - 1);
    return (ext + bias) >>> shift;
  endfunction

  function automatic sat_lim_t sat_limits(input int width);
    sat_lim_t                  lim;
    logic signed [ACC_WIDTH:0] one;
    one     = {{ACC_WIDTH{1'b0}}, 1'b1};
    lim.max = (one <<< (width - 1)) - one;
    lim.min = -(one <<< (width - 1));
    return lim;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sync_fifo: show-ahead FIFO with synchronous clear and async active-low
// reset.                                                     Rev 1.0
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int Width = 18,
  parameter int Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when indices match.
  always_comb begin
    empty_o = (wr_ptr_q == rd_ptr_q);
    full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    data_o  = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fir_output_conditioner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fir_output_conditioner: decimate, round, rescale and saturate the FIR
// accumulator stream into a small valid/ready output FIFO.   Rev 1.0
// ---------------------------------------------------------------------------
module fir_output_conditioner
  import fir_post_pkg::*;
#(
  parameter int DecimFactor = 4,
  parameter int ShiftRight  = 17,
  parameter int OutWidth    = OUT_WIDTH,
  parameter int FifoDepth   = 4
) (
  input  logic                 Clk_i,
  input  logic                 Rst_n_i,
  input  logic [ACC_WIDTH-1:0] Data_i,
  input  logic                 DataValid_i,
  input  logic                 Clear_i,
  output logic [OutWidth-1:0]  Data_o,
  output logic                 DataValid_o,
  input  logic                 DataReady_i,
  output logic                 SatFlag_o,
  output logic                 Overflow_o
);

  localparam int                        CNT_W    = (DecimFactor > 1) ? $clog2(DecimFactor) : 1;
  localparam logic [CNT_W-1:0]          CNT_LAST = CNT_W'(DecimFactor - 1);
  localparam sat_lim_t                  LIM      = sat_limits(OutWidth);
  localparam logic signed [ACC_WIDTH:0] SAT_MAX  = LIM.max;
  localparam logic signed [ACC_WIDTH:0] SAT_MIN  = LIM.min;

  logic [CNT_W-1:0]          dec_cnt_q;
  logic [CNT_W-1:0]          dec_cnt_d;
  logic                      keep;
  logic                      s1_valid_q;
  logic signed [ACC_WIDTH:0] s1_data_q;
  logic                      s2_valid_q;
  logic [OutWidth-1:0]       s2_data_q;
  logic [OutWidth-1:0]       sat_data;
  logic                      sat_hit;
  logic                      sat_q;
  logic                      ovf_q;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      fifo_pop;

  always_comb begin
    keep      = DataValid_i && (dec_cnt_q == '0);
    dec_cnt_d = dec_cnt_q;
    if (DataValid_i) begin
      dec_cnt_d = (dec_cnt_q == CNT_LAST) ? '0 : dec_cnt_q + 1'b1;
    end
  end

  always_comb begin
    sat_data = s1_data_q[OutWidth-1:0];
    sat_hit  = 1'b0;
    if (s1_data_q > SAT_MAX) begin
      sat_data = SAT_MAX[OutWidth-1:0];
      sat_hit  = 1'b1;
    end else if (s1_data_q < SAT_MIN) begin
      sat_data = SAT_MIN[OutWidth-1:0];
      sat_hit  = 1'b1;
    end
  end

  assign fifo_pop    = DataValid_o && DataReady_i;
  assign DataValid_o = !fifo_empty;
  assign SatFlag_o   = sat_q;
  assign Overflow_o  = ovf_q;

  // Clear outranks everything, including a strobe arriving in the same cycle.
  always_ff @(posedge Clk_i or negedge Rst_n_i) begin
    if (!Rst_n_i) begin
      dec_cnt_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      sat_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (Clear_i) begin
      dec_cnt_q  <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      sat_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      dec_cnt_q  <= dec_cnt_d;
      s1_valid_q <= keep;
      if (keep) begin
        s1_data_q <= round_shift($signed(Data_i), ShiftRight);
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q <= sat_data;
      end
      sat_q <= sat_q | (s1_valid_q & sat_hit);
      ovf_q <= ovf_q | (s2_valid_q & fifo_full & ~fifo_pop);
    end
  end

  sync_fifo #(
    .Width (OutWidth),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (Clk_i),
    .rst_n_i (Rst_n_i),
    .clr_i   (Clear_i),
    .push_i  (s2_valid_q),
    .data_i  (s2_data_q),
    .pop_i   (fifo_pop),
    .data_o  (Data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule
`default_nettype wire
